// File: rtl/peripheral_wb_pkg.sv
// Shared constants and state type for the Wishbone request bridge.
package peripheral_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WLOAD = 2'd1,
        BUS   = 2'd2,
        DRAIN = 2'd3
    } bridge_state_t;

endpackage

// File: rtl/peripheral_bridge_req_wb.sv
// Wishbone B3 master: turns cmd/wdat channels into classic or incrementing-burst cycles.
// Optional slave-response timeout when PERIPHERAL_WB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// WLOAD | cycle open, stb low, waiting for the next write beat
// BUS   | stb high, waiting for ack/err/rty (stb low here = retry gap)
// DRAIN | bus released after error, discarding leftover write beats
module peripheral_bridge_req_wb
    import peripheral_wb_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int LW = 4
`ifdef PERIPHERAL_WB_TIMEOUT_EN
    , parameter int TIMEOUT = 256
`endif
) (
    input  logic            i_wb_clk,
    input  logic            i_wb_rst,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic            i_cmd_we,
    input  logic [AW-1:0]   i_cmd_adr,
    input  logic [LW-1:0]   i_cmd_len,
    input  logic [DW/8-1:0] i_cmd_sel,
    input  logic            i_wdat_valid,
    output logic            o_wdat_ready,
    input  logic [DW-1:0]   i_wdat,
    output logic            o_rdat_valid,
    output logic [DW-1:0]   o_rdat,
    output logic            o_rsp_valid,
    output logic            o_rsp_err,
    output logic [AW-1:0]   o_wb_adr,
    output logic [DW-1:0]   o_wb_dat,
    output logic [DW/8-1:0] o_wb_sel,
    output logic            o_wb_we,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic [2:0]      o_wb_cti,
    output logic [1:0]      o_wb_bte,
    input  logic [DW-1:0]   i_wb_dat,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    input  logic            i_wb_rty
);

    bridge_state_t r_state;
    logic          r_we;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_cnt;

    logic          w_err;
    logic          w_last;
    logic          w_cmd_acc;
    logic          w_wdat_acc;
    logic [LW-1:0] w_cnt_nxt;
    logic [2:0]    w_cti_nxt;

    assign w_last     = (r_cnt == r_len);
    assign w_cmd_acc  = i_cmd_valid & o_cmd_ready;
    assign w_wdat_acc = i_wdat_valid & o_wdat_ready;
    assign w_cnt_nxt  = r_cnt + 1'b1;
    assign w_cti_nxt  = (w_cnt_nxt == r_len) ? CTI_END : CTI_INC;
    assign o_wb_bte   = BTE_LINEAR;

`ifdef PERIPHERAL_WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tmo;
    logic          w_tmo;

    // Reloads whenever stb is low or a beat completes, so each beat gets a fresh window.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst || !o_wb_stb || i_wb_ack || i_wb_err || i_wb_rty)
            r_tmo <= TW'(TIMEOUT - 1);
        else if (r_tmo != '0)
            r_tmo <= r_tmo - 1'b1;
    end

    assign w_tmo = o_wb_stb && (r_tmo == '0);
    assign w_err = i_wb_err | w_tmo;
`else
    assign w_err = i_wb_err;
`endif

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_state      <= IDLE;
            r_we         <= READ;
            r_len        <= '0;
            r_cnt        <= '0;
            o_cmd_ready  <= 1'b0;
            o_wdat_ready <= 1'b0;
            o_rdat_valid <= 1'b0;
            o_rdat       <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_err    <= 1'b0;
            o_wb_adr     <= '0;
            o_wb_dat     <= '0;
            o_wb_sel     <= '0;
            o_wb_we      <= 1'b0;
            o_wb_cyc     <= 1'b0;
            o_wb_stb     <= 1'b0;
            o_wb_cti     <= CTI_CLASSIC;
        end else begin
            o_rdat_valid <= 1'b0;
            o_rsp_valid  <= 1'b0;
            o_rsp_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Ready stays low in the cycle of rsp_valid, so a waiting command lands one cycle later.
                    o_cmd_ready <= 1'b1;
                    if (w_cmd_acc) begin
                        o_cmd_ready <= 1'b0;
                        r_we        <= i_cmd_we;
                        r_len       <= i_cmd_len;
                        r_cnt       <= '0;
                        o_wb_adr    <= i_cmd_adr;
                        o_wb_sel    <= i_cmd_sel;
                        o_wb_we     <= i_cmd_we;
                        o_wb_cyc    <= 1'b1;
                        o_wb_cti    <= (i_cmd_len == '0) ? CTI_CLASSIC : CTI_INC;
                        if (i_cmd_we == WRITE) begin
                            o_wdat_ready <= 1'b1;
                            r_state      <= WLOAD;
                        end else begin
                            o_wb_stb <= 1'b1;
                            r_state  <= BUS;
                        end
                    end
                end
                WLOAD: begin
                    if (w_wdat_acc) begin
                        o_wdat_ready <= 1'b0;
                        o_wb_dat     <= i_wdat;
                        o_wb_stb     <= 1'b1;
                        r_state      <= BUS;
                    end
                end
                BUS: begin
                    if (!o_wb_stb) begin
                        o_wb_stb <= 1'b1;
                    end else if (w_err) begin
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b1;
                        if (r_we == WRITE && !w_last) begin
                            // r_cnt now counts write beats still owed by the upstream
                            r_cnt        <= r_len - r_cnt;
                            o_wdat_ready <= 1'b1;
                            r_state      <= DRAIN;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (i_wb_ack) begin
                        if (r_we == READ) begin
                            o_rdat_valid <= 1'b1;
                            o_rdat       <= i_wb_dat;
                        end
                        if (w_last) begin
                            o_wb_cyc    <= 1'b0;
                            o_wb_stb    <= 1'b0;
                            o_rsp_valid <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            o_wb_adr <= o_wb_adr + AW'(DW / 8);
                            r_cnt    <= w_cnt_nxt;
                            o_wb_cti <= w_cti_nxt;
                            if (r_we == WRITE) begin
                                o_wb_stb     <= 1'b0;
                                o_wdat_ready <= 1'b1;
                                r_state      <= WLOAD;
                            end
                        end
                    end else if (i_wb_rty) begin
                        o_wb_stb <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (w_wdat_acc) begin
                        if (r_cnt == LW'(1)) begin
                            o_wdat_ready <= 1'b0;
                            r_state      <= IDLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
